// File: rtl/game_flow_controller_pkg.sv
// Shared symbols for the Pong match sequencer: phase encodings,
// parameter defaults and the player colours shown on the winner overlay.
package game_flow_controller_pkg;

    typedef enum logic [2:0] {
        GFC_IDLE     = 3'd0,
        GFC_SERVE    = 3'd1,
        GFC_PLAY     = 3'd2,
        GFC_PAUSED   = 3'd3,
        GFC_POINT    = 3'd4,
        GFC_GAMEOVER = 3'd5
    } state_t;

    localparam int WIN_SCORE_DEF        = 7;
    localparam int POINT_HOLD_TICKS_DEF = 60;
    localparam int GAMEOVER_TICKS_DEF   = 180;
    localparam int DEBOUNCE_TICKS_DEF   = 4;

    localparam logic [2:0] PLAYER_1_COLOR = 3'b100;
    localparam logic [2:0] PLAYER_2_COLOR = 3'b001;

endpackage

// File: rtl/game_flow_controller_if.sv
// Bundle between the match sequencer and the rest of the image generator.
// master = sequencer side, slave = ball/paddle/score-render side.
interface game_flow_controller_if;

    logic       tick;
    logic       key_pause_n;
    logic       miss_p1;
    logic       miss_p2;
    logic       run_enable;
    logic       serve_request;
    logic       serve_side;
    logic [2:0] score_1;
    logic [2:0] score_2;
    logic [2:0] winner_color;
    logic [2:0] phase;

    modport master (
        input  tick, key_pause_n, miss_p1, miss_p2,
        output run_enable, serve_request, serve_side,
               score_1, score_2, winner_color, phase
    );

    modport slave (
        output tick, key_pause_n, miss_p1, miss_p2,
        input  run_enable, serve_request, serve_side,
               score_1, score_2, winner_color, phase
    );

endinterface

// File: rtl/game_flow_controller_key_debouncer.sv
// Key debouncer: 2-flop synchroniser, tick-based stability counter and a
// press strobe that is high on the tick where the debounced level falls.
module key_debouncer #(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic key_n,
    output logic press
);

    logic       sync_a;
    logic       sync_b;
    logic       level;
    logic [3:0] stable_cnt;
    logic       settle;

    // Synchronise the raw key on every clock; idle level is released (1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= key_n;
            sync_b <= sync_a;
        end
    end

    // Last of the required consecutive ticks that sampled the new level.
    assign settle = tick && (sync_b != level) &&
                    (stable_cnt == 4'(DEBOUNCE_TICKS - 1));

    // Count consecutive differing ticks; any agreeing sample restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level      <= 1'b1;
            stable_cnt <= 4'd0;
        end else if (tick) begin
            if (sync_b == level) begin
                stable_cnt <= 4'd0;
            end else if (settle) begin
                level      <= sync_b;
                stable_cnt <= 4'd0;
            end else begin
                stable_cnt <= stable_cnt + 4'd1;
            end
        end
    end

    // Level is still 1 while settling toward 0, so this marks the falling edge.
    assign press = settle && level;

endmodule

// File: rtl/game_flow_controller.sv
// Match-level sequencer for Pong: pause/serve/point/game-over flow, both
// scores and the winner colour. All state advances on the ball-clock tick.
module game_flow_controller
    import game_flow_controller_pkg::*;
#(
    parameter int WIN_SCORE        = WIN_SCORE_DEF,
    parameter int POINT_HOLD_TICKS = POINT_HOLD_TICKS_DEF,
    parameter int GAMEOVER_TICKS   = GAMEOVER_TICKS_DEF,
    parameter int DEBOUNCE_TICKS   = DEBOUNCE_TICKS_DEF
) (
    input logic                    CLOCK_25,
    input logic                    RESET_N,
    game_flow_controller_if.master bus
);

    state_t     state, state_nx;
    logic [2:0] score_1, score_1_nx, score_1_inc;
    logic [2:0] score_2, score_2_nx, score_2_inc;
    logic [2:0] winner, winner_nx;
    logic [7:0] hold_cnt, hold_cnt_nx;
    logic       serve_side, serve_side_nx;
    logic       serve_req, serve_req_nx;
    logic       pend1, pend2;
    logic       press;

    key_debouncer #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_pause_key (
        .clk  (CLOCK_25),
        .rst_n(RESET_N),
        .tick (bus.tick),
        .key_n(bus.key_pause_n),
        .press(press)
    );

    assign score_1_inc = score_1 + 3'd1;
    assign score_2_inc = score_2 + 3'd1;

    // Latch miss pulses between ticks; a tick consumes them unless a new pulse lands on it.
    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            pend1 <= 1'b0;
            pend2 <= 1'b0;
        end else begin
            pend1 <= bus.miss_p1 | (pend1 & ~bus.tick);
            pend2 <= bus.miss_p2 | (pend2 & ~bus.tick);
        end
    end

    // Register the sequencer state and everything it owns.
    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= GFC_IDLE;
            score_1    <= 3'd0;
            score_2    <= 3'd0;
            winner     <= 3'd0;
            hold_cnt   <= 8'd0;
            serve_side <= 1'b0;
            serve_req  <= 1'b0;
        end else begin
            state      <= state_nx;
            score_1    <= score_1_nx;
            score_2    <= score_2_nx;
            winner     <= winner_nx;
            hold_cnt   <= hold_cnt_nx;
            serve_side <= serve_side_nx;
            serve_req  <= serve_req_nx;
        end
    end

    // Next-state rules, evaluated only on tick clocks.
    always_comb begin
        state_nx      = state;
        score_1_nx    = score_1;
        score_2_nx    = score_2;
        winner_nx     = winner;
        hold_cnt_nx   = hold_cnt;
        serve_side_nx = serve_side;
        serve_req_nx  = 1'b0;
        if (bus.tick) begin
            case (state)
                GFC_IDLE: begin
                    if (press) begin
                        state_nx  = GFC_SERVE;
                        winner_nx = 3'd0;
                    end
                end
                GFC_SERVE: begin
                    serve_req_nx = 1'b1;
                    state_nx     = GFC_PLAY;
                end
                GFC_PLAY: begin
                    // A miss outranks a press; the press is simply dropped.
                    if (pend1 && pend2) begin
                        hold_cnt_nx = 8'd0;
                        state_nx    = GFC_POINT;
                    end else if (pend1) begin
                        score_2_nx    = score_2_inc;
                        serve_side_nx = 1'b1;
                        hold_cnt_nx   = 8'd0;
                        if (score_2_inc == 3'(WIN_SCORE)) begin
                            winner_nx = PLAYER_2_COLOR;
                            state_nx  = GFC_GAMEOVER;
                        end else begin
                            state_nx  = GFC_POINT;
                        end
                    end else if (pend2) begin
                        score_1_nx    = score_1_inc;
                        serve_side_nx = 1'b0;
                        hold_cnt_nx   = 8'd0;
                        if (score_1_inc == 3'(WIN_SCORE)) begin
                            winner_nx = PLAYER_1_COLOR;
                            state_nx  = GFC_GAMEOVER;
                        end else begin
                            state_nx  = GFC_POINT;
                        end
                    end else if (press) begin
                        state_nx = GFC_PAUSED;
                    end
                end
                GFC_PAUSED: begin
                    if (press) begin
                        state_nx = GFC_PLAY;
                    end
                end
                GFC_POINT: begin
                    if (hold_cnt == 8'(POINT_HOLD_TICKS - 1)) begin
                        state_nx = GFC_SERVE;
                    end else begin
                        hold_cnt_nx = hold_cnt + 8'd1;
                    end
                end
                GFC_GAMEOVER: begin
                    if (hold_cnt == 8'(GAMEOVER_TICKS - 1)) begin
                        score_1_nx    = 3'd0;
                        score_2_nx    = 3'd0;
                        serve_side_nx = 1'b0;
                        state_nx      = GFC_IDLE;
                    end else begin
                        hold_cnt_nx = hold_cnt + 8'd1;
                    end
                end
                default: begin
                    state_nx = GFC_IDLE;
                end
            endcase
        end
    end

    assign bus.run_enable    = (state == GFC_PLAY);
    assign bus.phase         = state;
    assign bus.serve_request = serve_req;
    assign bus.serve_side    = serve_side;
    assign bus.score_1       = score_1;
    assign bus.score_2       = score_2;
    assign bus.winner_color  = winner;

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for the Pong match sequencer: directed scenarios followed by a
// long randomized run, all checked against a tick-level match model.
module tb_game_flow_controller;
    import game_flow_controller_pkg::*;

    localparam int WIN  = 7;
    localparam int HOLD = 60;
    localparam int GO   = 180;
    localparam int DEB  = 4;

    localparam int P_IDLE = 0, P_SERVE = 1, P_PLAY = 2;
    localparam int P_PAUSED = 3, P_POINT = 4, P_GAMEOVER = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    game_flow_controller_if bus();

    game_flow_controller #(
        .WIN_SCORE       (WIN),
        .POINT_HOLD_TICKS(HOLD),
        .GAMEOVER_TICKS  (GO),
        .DEBOUNCE_TICKS  (DEB)
    ) dut (
        .CLOCK_25(clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    always #20 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int sr_seen = 0;

    // Clocks on which serve_request was observed high.
    always @(negedge clk) if (bus.serve_request === 1'b1) sr_seen++;

    // Match model state.
    int m_phase, m_s1, m_s2, m_side, m_win, m_ticks, m_sr, m_deb;
    int hist[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_s1 = 0; m_s2 = 0; m_side = 0; m_win = 0;
        m_ticks = 0; m_deb = 1;
        hist.delete();
    endtask

    // One game tick: key level sampled now, misses seen since the last tick.
    task automatic model_tick(input int k, input int m1, input int m2);
        int press;
        int all_same;
        press = 0;
        hist.push_back(k);
        if (hist.size() > DEB) hist.delete(0);
        if (hist.size() == DEB && k != m_deb) begin
            all_same = 1;
            foreach (hist[i]) if (hist[i] != k) all_same = 0;
            if (all_same != 0) begin
                m_deb = k;
                press = (k == 0) ? 1 : 0;
            end
        end
        case (m_phase)
            P_IDLE:   if (press != 0) begin m_phase = P_SERVE; m_win = 0; end
            P_SERVE:  begin m_sr++; m_phase = P_PLAY; end
            P_PLAY: begin
                if (m1 != 0 && m2 != 0) begin
                    m_phase = P_POINT; m_ticks = 0;
                end else if (m1 != 0) begin
                    m_s2++; m_side = 1; m_ticks = 0;
                    if (m_s2 == WIN) begin m_win = PLAYER_2_COLOR; m_phase = P_GAMEOVER; end
                    else m_phase = P_POINT;
                end else if (m2 != 0) begin
                    m_s1++; m_side = 0; m_ticks = 0;
                    if (m_s1 == WIN) begin m_win = PLAYER_1_COLOR; m_phase = P_GAMEOVER; end
                    else m_phase = P_POINT;
                end else if (press != 0) begin
                    m_phase = P_PAUSED;
                end
            end
            P_PAUSED: if (press != 0) m_phase = P_PLAY;
            P_POINT: begin
                m_ticks++;
                if (m_ticks == HOLD) m_phase = P_SERVE;
            end
            P_GAMEOVER: begin
                m_ticks++;
                if (m_ticks == GO) begin
                    m_s1 = 0; m_s2 = 0; m_side = 0; m_phase = P_IDLE;
                end
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic check_all();
        chk("phase",        bus.phase,        m_phase);
        chk("run_enable",   bus.run_enable,   (m_phase == P_PLAY) ? 1 : 0);
        chk("score_1",      bus.score_1,      m_s1);
        chk("score_2",      bus.score_2,      m_s2);
        chk("serve_side",   bus.serve_side,   m_side);
        chk("winner_color", bus.winner_color, m_win);
        chk("serve_pulses", sr_seen,          m_sr);
    endtask

    // Hold key for a full step, pulse misses for one clock, then issue one tick.
    task automatic step(input int k, input int m1, input int m2);
        @(negedge clk);
        bus.key_pause_n = 1'(k);
        bus.miss_p1 = 1'(m1);
        bus.miss_p2 = 1'(m2);
        @(negedge clk);
        bus.miss_p1 = 1'b0;
        bus.miss_p2 = 1'b0;
        @(negedge clk);
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
        #1;
        model_tick(k, m1, m2);
        check_all();
    endtask

    initial begin
        int intent;
        int k, r, m1, m2;
        bus.tick = 1'b0;
        bus.key_pause_n = 1'b1;
        bus.miss_p1 = 1'b0;
        bus.miss_p2 = 1'b0;
        m_sr = 0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_all();
        chk("reset_serve_request", bus.serve_request, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Start a match.
        repeat (6) step(0, 0, 0);
        chk("start_phase", bus.phase, P_PLAY);
        chk("start_serves", sr_seen, 1);
        repeat (DEB) step(1, 0, 0);

        // Player 1 misses: point to player 2, then hold and re-serve.
        step(1, 1, 0);
        chk("miss1_score_2", bus.score_2, 1);
        chk("miss1_side", bus.serve_side, 1);
        chk("miss1_phase", bus.phase, P_POINT);
        repeat (HOLD) step(1, 0, 0);
        chk("hold_end_phase", bus.phase, P_SERVE);
        step(1, 0, 0);
        chk("reserve_phase", bus.phase, P_PLAY);
        chk("reserve_serves", sr_seen, 2);

        // Player 1 runs up to the winning score.
        for (int i = 0; i < WIN; i++) begin
            step(1, 0, 1);
            if (i < WIN - 1) repeat (HOLD + 1) step(1, 0, 0);
        end
        chk("win_score_1", bus.score_1, WIN);
        chk("win_color", bus.winner_color, PLAYER_1_COLOR);
        chk("win_phase", bus.phase, P_GAMEOVER);
        repeat (GO - 1) step(1, 0, 0);
        chk("gameover_hold", bus.phase, P_GAMEOVER);
        step(1, 0, 0);
        chk("gameover_idle", bus.phase, P_IDLE);
        chk("gameover_clear", bus.score_1, 0);
        chk("gameover_color_kept", bus.winner_color, PLAYER_1_COLOR);

        // Next press clears the winner.
        repeat (DEB) step(0, 0, 0);
        chk("new_game_color", bus.winner_color, 0);
        repeat (2) step(0, 0, 0);
        repeat (DEB) step(1, 0, 0);

        // Pause, ignore a miss while paused, resume.
        repeat (DEB) step(0, 0, 0);
        chk("paused_phase", bus.phase, P_PAUSED);
        chk("paused_run", bus.run_enable, 0);
        step(0, 1, 0);
        chk("paused_miss_score_2", bus.score_2, 0);
        repeat (DEB) step(1, 0, 0);
        repeat (DEB) step(0, 0, 0);
        chk("resume_phase", bus.phase, P_PLAY);
        repeat (DEB) step(1, 0, 0);

        // Bouncing key never settles.
        for (int i = 0; i < 20; i++) step(i % 2, 0, 0);
        chk("bounce_phase", bus.phase, P_PLAY);

        // Press lands on the same tick as a miss: the miss wins.
        repeat (DEB - 1) step(0, 0, 0);
        step(0, 0, 1);
        chk("press_miss_score_1", bus.score_1, 1);
        chk("press_miss_phase", bus.phase, P_POINT);
        repeat (DEB) step(1, 0, 0);

        // Asynchronous reset in the middle of a point hold.
        @(posedge clk);
        #7;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("midreset_serve_request", bus.serve_request, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized play.
        intent = 1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 29) == 0) intent = 1 - intent;
            k = intent;
            if ($urandom_range(0, 9) == 0) k = 1 - k;
            r = int'($urandom_range(0, 15));
            m1 = (r == 0 || r == 2) ? 1 : 0;
            m2 = (r == 1 || r == 2) ? 1 : 0;
            step(k, m1, m2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
